// File: rtl/nexys_starship_monster_ctrl.sv
// Monster controller for the starship game: one IDLE/ACTIVE/COOLDOWN FSM per
// direction plus game run/over and score. Define STARSHIP_SCORE_SAT_EN to saturate the score at 255.
module nexys_starship_monster_ctrl #(
    parameter int TIMEOUT_CYC  = 200000000,
    parameter int COOLDOWN_CYC = 50000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  spawn_req,
    input  logic [3:0]  random_hex,
    input  logic [3:0]  shoot,
    input  logic [3:0]  shoot_hex,
    output logic [3:0]  monster_active,
    output logic [15:0] monster_hex,
    output logic        running,
    output logic        game_over,
    output logic [7:0]  score
);

    localparam int MAX_CYC = (TIMEOUT_CYC > COOLDOWN_CYC) ? TIMEOUT_CYC : COOLDOWN_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] CD_LAST    = TW'(COOLDOWN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t          r_state     [4];
    state_t          w_state_nxt [4];
    logic [TW-1:0]   r_timer     [4];
    logic [TW-1:0]   w_timer_nxt [4];
    logic [3:0]      r_hex       [4];
    logic [3:0]      w_hex_nxt   [4];
    logic [3:0]      r_active;
    logic [3:0]      w_active_nxt;
    logic            r_running;
    logic            w_running_nxt;
    logic            r_game_over;
    logic            w_game_over_nxt;
    logic [7:0]      r_score;
    logic [7:0]      w_score_nxt;
    logic [3:0]      w_kill;
    logic [3:0]      w_timeout;

    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [7:0] add_score(input logic [7:0] s, input logic [2:0] n);
`ifdef STARSHIP_SCORE_SAT_EN
        logic [8:0] sum;
        sum = {1'b0, s} + {6'b000000, n};
        if (sum > 9'd255) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
`else
        return s + {5'b00000, n};
`endif
    endfunction

    // Next-state logic for all four direction FSMs and the game-level flags.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            w_state_nxt[d] = r_state[d];
            w_timer_nxt[d] = r_timer[d];
            w_hex_nxt[d]   = r_hex[d];
        end
        w_kill          = 4'b0000;
        w_timeout       = 4'b0000;
        w_running_nxt   = r_running;
        w_game_over_nxt = r_game_over;

        if (start && !r_running) begin
            w_running_nxt   = 1'b1;
            w_game_over_nxt = 1'b0;
            for (int d = 0; d < 4; d++) begin
                w_state_nxt[d] = ST_IDLE;
                w_timer_nxt[d] = TIMER_ZERO;
            end
        end else if (r_running) begin
            for (int d = 0; d < 4; d++) begin
                case (r_state[d])
                    ST_IDLE: begin
                        // A same-cycle shoot on an idle direction is simply not looked at here.
                        if (spawn_req[d]) begin
                            w_state_nxt[d] = ST_ACTIVE;
                            w_hex_nxt[d]   = random_hex;
                            w_timer_nxt[d] = TIMER_ZERO;
                        end else begin
                            w_state_nxt[d] = ST_IDLE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (shoot[d] && (shoot_hex == r_hex[d])) begin
                            w_kill[d]      = 1'b1;
                            w_state_nxt[d] = ST_COOLDOWN;
                            w_timer_nxt[d] = TIMER_ZERO;
                        end else if (r_timer[d] == TO_LAST) begin
                            w_timeout[d]   = 1'b1;
                        end else begin
                            w_timer_nxt[d] = r_timer[d] + TIMER_ONE;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (r_timer[d] == CD_LAST) begin
                            w_state_nxt[d] = ST_IDLE;
                            w_timer_nxt[d] = TIMER_ZERO;
                        end else begin
                            w_timer_nxt[d] = r_timer[d] + TIMER_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt[d] = ST_IDLE;
                        w_timer_nxt[d] = TIMER_ZERO;
                    end
                endcase
            end
            if (|w_timeout) begin
                w_running_nxt   = 1'b1 ^ 1'b1;
                w_game_over_nxt = 1'b1;
                for (int d = 0; d < 4; d++) begin
                    w_state_nxt[d] = ST_IDLE;
                    w_timer_nxt[d] = TIMER_ZERO;
                end
            end else begin
                w_game_over_nxt = r_game_over;
            end
        end else begin
            w_running_nxt = 1'b0;
        end
    end

    // Score update: cleared by a new game, otherwise advanced by this cycle's kill count.
    always_comb begin
        w_score_nxt = r_score;
        if (start && !r_running) begin
            w_score_nxt = 8'h00;
        end else if (r_running) begin
            w_score_nxt = add_score(r_score, count_ones4(w_kill));
        end else begin
            w_score_nxt = r_score;
        end
    end

    // Registered presence flags follow the next FSM state so outputs leave flops directly.
    always_comb begin
        w_active_nxt = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            w_active_nxt[d] = (w_state_nxt[d] == ST_ACTIVE);
        end
    end

    // State register for FSMs, timers, codes, flags and score.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int d = 0; d < 4; d++) begin
                r_state[d] <= ST_IDLE;
                r_timer[d] <= TIMER_ZERO;
                r_hex[d]   <= 4'h0;
            end
            r_active    <= 4'b0000;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
            r_score     <= 8'h00;
        end else begin
            for (int d = 0; d < 4; d++) begin
                r_state[d] <= w_state_nxt[d];
                r_timer[d] <= w_timer_nxt[d];
                r_hex[d]   <= w_hex_nxt[d];
            end
            r_active    <= w_active_nxt;
            r_running   <= w_running_nxt;
            r_game_over <= w_game_over_nxt;
            r_score     <= w_score_nxt;
        end
    end

    assign monster_active = r_active;
    assign monster_hex    = {r_hex[3], r_hex[2], r_hex[1], r_hex[0]};
    assign running        = r_running;
    assign game_over      = r_game_over;
    assign score          = r_score;

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Self-checking bench for nexys_starship_monster_ctrl (TIMEOUT_CYC=20, COOLDOWN_CYC=5):
// table-driven vectors plus hand-written multi-cycle sequences, checked via a scoreboard queue.
module tb_nexys_starship_monster_ctrl;

    localparam int TO_CYC = 20;
    localparam int CD_CYC = 5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [3:0]  spawn_req;
    logic [3:0]  random_hex;
    logic [3:0]  shoot;
    logic [3:0]  shoot_hex;
    logic [3:0]  monster_active;
    logic [15:0] monster_hex;
    logic        running;
    logic        game_over;
    logic [7:0]  score;

    nexys_starship_monster_ctrl #(
        .TIMEOUT_CYC  (TO_CYC),
        .COOLDOWN_CYC (CD_CYC)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .start          (start),
        .spawn_req      (spawn_req),
        .random_hex     (random_hex),
        .shoot          (shoot),
        .shoot_hex      (shoot_hex),
        .monster_active (monster_active),
        .monster_hex    (monster_hex),
        .running        (running),
        .game_over      (game_over),
        .score          (score)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]  act;
        logic [15:0] hex;
        logic        run;
        logic        go;
        logic [7:0]  score;
    } exp_t;

    typedef struct {
        logic       start;
        logic [3:0] spawn;
        logic [3:0] rhex;
        logic [3:0] shoot;
        logic [3:0] shex;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[19];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t mk(input logic [3:0] a, input logic [15:0] h,
                                input logic r, input logic g, input logic [7:0] s);
        return {a, h, r, g, s};
    endfunction

    function automatic vec_t mv(input logic st, input logic [3:0] sp, input logic [3:0] rh,
                                input logic [3:0] sh, input logic [3:0] shx, input exp_t e);
        vec_t v;
        v.start = st; v.spawn = sp; v.rhex = rh; v.shoot = sh; v.shex = shx; v.e = e;
        return v;
    endfunction

    task automatic compare(input exp_t e, input string tag);
        exp_t got;
        got = {monster_active, monster_hex, running, game_over, score};
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL %s: got act=%b hex=%h run=%b go=%b score=%0d, expected act=%b hex=%h run=%b go=%b score=%0d",
                     tag, got.act, got.hex, got.run, got.go, got.score,
                     e.act, e.hex, e.run, e.go, e.score);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic cyc(input logic st, input logic [3:0] sp, input logic [3:0] rh,
                       input logic [3:0] sh, input logic [3:0] shx, input exp_t e, input string tag);
        @(negedge Clk);
        start = st; spawn_req = sp; random_hex = rh; shoot = sh; shoot_hex = shx;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            compare(sb_q.pop_front(), tag);
        end
    endtask

    task automatic idle(input int n, input exp_t e, input string tag);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, e, tag);
        end
    endtask

    initial begin
        int           sc;
        logic [3:0]   h;
        logic [7:0]   sc_final;

        Reset = 1'b0; start = 1'b0; spawn_req = 4'h0; random_hex = 4'h0;
        shoot = 4'h0; shoot_hex = 4'h0;

        tbl[0]  = mv(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b0000, 16'h0000, 1'b1, 1'b0, 8'd0));
        tbl[1]  = mv(1'b0, 4'h8, 4'hA, 4'h0, 4'h0, mk(4'b1000, 16'hA000, 1'b1, 1'b0, 8'd0));
        tbl[2]  = mv(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b1000, 16'hA000, 1'b1, 1'b0, 8'd0));
        tbl[3]  = mv(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b1000, 16'hA000, 1'b1, 1'b0, 8'd0));
        tbl[4]  = mv(1'b0, 4'h0, 4'h0, 4'h8, 4'hA, mk(4'b0000, 16'hA000, 1'b1, 1'b0, 8'd1));
        tbl[5]  = mv(1'b0, 4'h1, 4'h3, 4'h0, 4'h0, mk(4'b0001, 16'hA003, 1'b1, 1'b0, 8'd1));
        tbl[6]  = mv(1'b0, 4'h0, 4'h0, 4'h1, 4'h4, mk(4'b0001, 16'hA003, 1'b1, 1'b0, 8'd1));
        tbl[7]  = mv(1'b0, 4'h0, 4'h0, 4'h2, 4'h3, mk(4'b0001, 16'hA003, 1'b1, 1'b0, 8'd1));
        tbl[8]  = mv(1'b0, 4'h0, 4'h0, 4'h1, 4'h3, mk(4'b0000, 16'hA003, 1'b1, 1'b0, 8'd2));
        for (int i = 9; i <= 13; i++) begin
            tbl[i] = mv(1'b0, 4'h1, 4'h5, 4'h0, 4'h0, mk(4'b0000, 16'hA003, 1'b1, 1'b0, 8'd2));
        end
        tbl[14] = mv(1'b0, 4'h1, 4'h7, 4'h0, 4'h0, mk(4'b0001, 16'hA007, 1'b1, 1'b0, 8'd2));
        tbl[15] = mv(1'b0, 4'h4, 4'h9, 4'h4, 4'h9, mk(4'b0101, 16'hA907, 1'b1, 1'b0, 8'd2));
        tbl[16] = mv(1'b0, 4'h0, 4'h0, 4'h5, 4'h7, mk(4'b0100, 16'hA907, 1'b1, 1'b0, 8'd3));
        tbl[17] = mv(1'b0, 4'h0, 4'h0, 4'h4, 4'h9, mk(4'b0000, 16'hA907, 1'b1, 1'b0, 8'd4));
        tbl[18] = mv(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b0000, 16'hA907, 1'b1, 1'b0, 8'd4));

        #12;
        compare(mk(4'b0000, 16'h0000, 1'b0, 1'b0, 8'd0), "reset_state");
        @(negedge Clk);
        Reset = 1'b1;
        cyc(1'b0, 4'h8, 4'hA, 4'h0, 4'h0, mk(4'b0000, 16'h0000, 1'b0, 1'b0, 8'd0), "spawn_before_start");

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].start, tbl[i].spawn, tbl[i].rhex, tbl[i].shoot, tbl[i].shex,
                tbl[i].e, $sformatf("vec%0d", i));
        end

        // Timeout on the left monster ends the game.
        cyc(1'b0, 4'h2, 4'h1, 4'h0, 4'h0, mk(4'b0010, 16'hA917, 1'b1, 1'b0, 8'd4), "to_spawn");
        idle(TO_CYC - 1, mk(4'b0010, 16'hA917, 1'b1, 1'b0, 8'd4), "to_wait");
        idle(1, mk(4'b0000, 16'hA917, 1'b0, 1'b1, 8'd4), "to_fire");
        cyc(1'b0, 4'h8, 4'hF, 4'h8, 4'hF, mk(4'b0000, 16'hA917, 1'b0, 1'b1, 8'd4), "to_ignored");
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b0000, 16'hA917, 1'b1, 1'b0, 8'd0), "restart");

        // Four simultaneous kills, then a kill landing on the timeout cycle.
        cyc(1'b0, 4'hF, 4'hB, 4'h0, 4'h0, mk(4'b1111, 16'hBBBB, 1'b1, 1'b0, 8'd0), "spawn4");
        cyc(1'b0, 4'h0, 4'h0, 4'hF, 4'hB, mk(4'b0000, 16'hBBBB, 1'b1, 1'b0, 8'd4), "kill4");
        idle(CD_CYC, mk(4'b0000, 16'hBBBB, 1'b1, 1'b0, 8'd4), "cool4");
        cyc(1'b0, 4'h8, 4'hC, 4'h0, 4'h0, mk(4'b1000, 16'hCBBB, 1'b1, 1'b0, 8'd4), "late_spawn");
        idle(TO_CYC - 1, mk(4'b1000, 16'hCBBB, 1'b1, 1'b0, 8'd4), "late_wait");
        cyc(1'b0, 4'h0, 4'h0, 4'h8, 4'hC, mk(4'b0000, 16'hCBBB, 1'b1, 1'b0, 8'd5), "kill_on_timeout");

        // Two directions time out together: one game over, score untouched.
        idle(CD_CYC, mk(4'b0000, 16'hCBBB, 1'b1, 1'b0, 8'd5), "cool_late");
        cyc(1'b0, 4'h6, 4'hD, 4'h0, 4'h0, mk(4'b0110, 16'hCDDB, 1'b1, 1'b0, 8'd5), "spawn2");
        idle(TO_CYC - 1, mk(4'b0110, 16'hCDDB, 1'b1, 1'b0, 8'd5), "wait2");
        idle(1, mk(4'b0000, 16'hCDDB, 1'b0, 1'b1, 8'd5), "multi_timeout");

        // Drive the score to 254 then land two kills together.
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b0000, 16'hCDDB, 1'b1, 1'b0, 8'd0), "restart2");
        sc = 0;
        for (int r = 0; r < 63; r++) begin
            h = 4'(r);
            cyc(1'b0, 4'hF, h, 4'h0, 4'h0, mk(4'b1111, {4{h}}, 1'b1, 1'b0, 8'(sc)), "round_spawn");
            sc = sc + 4;
            cyc(1'b0, 4'h0, 4'h0, 4'hF, h, mk(4'b0000, {4{h}}, 1'b1, 1'b0, 8'(sc)), "round_kill");
            idle(CD_CYC, mk(4'b0000, {4{h}}, 1'b1, 1'b0, 8'(sc)), "round_cool");
        end
        cyc(1'b0, 4'h3, 4'h5, 4'h0, 4'h0, mk(4'b0011, 16'hEE55, 1'b1, 1'b0, 8'd252), "pre_spawn");
        cyc(1'b0, 4'h0, 4'h0, 4'h3, 4'h5, mk(4'b0000, 16'hEE55, 1'b1, 1'b0, 8'd254), "score_254");
        idle(CD_CYC, mk(4'b0000, 16'hEE55, 1'b1, 1'b0, 8'd254), "cool_254");
        cyc(1'b0, 4'h3, 4'h6, 4'h0, 4'h0, mk(4'b0011, 16'hEE66, 1'b1, 1'b0, 8'd254), "limit_spawn");
`ifdef STARSHIP_SCORE_SAT_EN
        sc_final = 8'd255;
`else
        sc_final = 8'd0;
`endif
        cyc(1'b0, 4'h0, 4'h0, 4'h3, 4'h6, mk(4'b0000, 16'hEE66, 1'b1, 1'b0, sc_final), "score_limit");
        idle(CD_CYC, mk(4'b0000, 16'hEE66, 1'b1, 1'b0, sc_final), "cool_limit");

        // Asynchronous reset in the middle of a game.
        cyc(1'b0, 4'hF, 4'h7, 4'h0, 4'h0, mk(4'b1111, 16'h7777, 1'b1, 1'b0, sc_final), "pre_reset");
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1 compare(mk(4'b0000, 16'h0000, 1'b0, 1'b0, 8'd0), "async_reset");
        @(negedge Clk);
        Reset = 1'b1;
        cyc(1'b0, 4'h8, 4'hA, 4'h0, 4'h0, mk(4'b0000, 16'h0000, 1'b0, 1'b0, 8'd0), "no_spawn_wo_start");
        cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, mk(4'b0000, 16'h0000, 1'b1, 1'b0, 8'd0), "start_after_reset");
        cyc(1'b0, 4'h8, 4'hA, 4'h0, 4'h0, mk(4'b1000, 16'hA000, 1'b1, 1'b0, 8'd0), "spawn_after_reset");

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
